multdiv: RTL and testbench



---
 rtl/multdiv_pkg.sv | 11 +
 rtl/div_step.sv | 14 +
 rtl/multdiv.sv | 114 +++++++++++
 tb/tb_multdiv.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM state type and iteration constants for the multiply/divide unit (MULTDIV_RADIX4_EN selects 16-step Booth multiply)
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  localparam int MD_WIDTH = 32;
`ifdef MULTDIV_RADIX4_EN
  localparam int MD_MULT_ITERS = 16;
`else
  localparam int MD_MULT_ITERS = 32;
`endif
  localparam int MD_DIV_ITERS = 32;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step; ports rem/dvd_bit/dsr in, rem_nx/q_bit out
module div_step (
  input  logic [31:0] rem,
  input  logic        dvd_bit,
  input  logic [31:0] dsr,
  output logic [31:0] rem_nx,
  output logic        q_bit
);
  logic [32:0] shifted;
  assign shifted = {rem, dvd_bit};
  assign q_bit = shifted >= {1'b0, dsr};
  // when the subtraction succeeds the difference is below dsr, so 32-bit modular math is exact
  assign rem_nx = q_bit ? shifted[31:0] - dsr : shifted[31:0];
endmodule

// File: rtl/multdiv.sv
// multdiv: iterative signed 32-bit multiply/divide; ports clock, reset_n, data_operandA/B, ctrl_MULT/DIV in, data_result, data_exception, data_resultRDY out; MULTDIV_RADIX4_EN selects radix-4 Booth multiply
module multdiv (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);
  import multdiv_pkg::*;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic [63:0] prod, prod_fin;
  logic [31:0] dsr, a_mag, b_mag, rem_nx, quo;
  logic neg, is_div, div_exc, q_bit, start, b_zero;
`ifdef MULTDIV_RADIX4_EN
  logic [63:0] mc, booth;
  logic [32:0] mq;
`else
  logic [32:0] sum;
`endif
  assign start = ctrl_MULT | ctrl_DIV;
  assign a_mag = data_operandA[31] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[31] ? -data_operandB : data_operandB;
  assign b_zero = data_operandB == '0;
  assign prod_fin = neg ? -prod : prod;
  assign quo = neg ? -prod[31:0] : prod[31:0];
  // divide keeps the partial remainder in prod[63:32] and shifts quotient bits into prod[31:0]
  div_step u_step (
    .rem    (prod[63:32]),
    .dvd_bit(prod[31]),
    .dsr    (dsr),
    .rem_nx (rem_nx),
    .q_bit  (q_bit)
  );
`ifdef MULTDIV_RADIX4_EN
  // Booth digit from multiplier bits {b(2i+1), b(2i), b(2i-1)} applied to the pre-shifted signed multiplicand
  always_comb begin
    booth = (mq[2:0] == 3'b001 || mq[2:0] == 3'b010) ? mc :
            (mq[2:0] == 3'b011) ? mc << 1 :
            (mq[2:0] == 3'b100) ? -(mc << 1) :
            (mq[2:0] == 3'b101 || mq[2:0] == 3'b110) ? -mc : '0;
  end
`else
  assign sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, dsr} : 33'd0);
`endif
  always_comb begin
    state_nx = state;
    if (ctrl_MULT) state_nx = MULT;
    else if (ctrl_DIV) state_nx = b_zero ? DONE : DIV;
    else if (state == MULT) state_nx = (cnt == 6'(MD_MULT_ITERS - 1)) ? DONE : MULT;
    else if (state == DIV) state_nx = (cnt == 6'(MD_DIV_ITERS - 1)) ? DONE : DIV;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      prod <= '0;
      dsr <= '0;
      neg <= 1'b0;
      is_div <= 1'b0;
      div_exc <= 1'b0;
      data_result <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef MULTDIV_RADIX4_EN
      mc <= '0;
      mq <= '0;
`endif
    end else begin
      data_resultRDY <= state == DONE;
      if (state == DONE) begin
        data_result <= is_div ? quo : prod_fin[31:0];
        data_exception <= is_div ? div_exc : prod_fin[63:32] != {32{prod_fin[31]}};
      end
      if (start) begin
        cnt <= '0;
        is_div <= !ctrl_MULT;
        dsr <= ctrl_MULT ? a_mag : b_mag;
        neg <= data_operandA[31] ^ data_operandB[31];
        div_exc <= !ctrl_MULT && (b_zero || (data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF));
        prod <= {32'd0, ctrl_MULT ? b_mag : (b_zero ? 32'd0 : a_mag)};
`ifdef MULTDIV_RADIX4_EN
        // Booth works directly on signed operands, so no sign fix-up is needed afterwards
        if (ctrl_MULT) begin
          neg <= 1'b0;
          prod <= '0;
        end
        mc <= {{32{data_operandA[31]}}, data_operandA};
        mq <= {data_operandB, 1'b0};
`endif
      end else if (state == MULT) begin
        cnt <= cnt + 6'd1;
`ifdef MULTDIV_RADIX4_EN
        prod <= prod + booth;
        mc <= mc << 2;
        mq <= {{2{mq[32]}}, mq[32:2]};
`else
        prod <= {sum, prod[31:1]};
`endif
      end else if (state == DIV) begin
        cnt <= cnt + 6'd1;
        prod <= {rem_nx, prod[30:0], q_bit};
      end
    end
  end
endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed self-checking bench for multdiv
module tb_multdiv;
`ifdef MULTDIV_RADIX4_EN
  localparam int ML = 17;
`else
  localparam int ML = 33;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic ctrl_mult = 1'b0, ctrl_div = 1'b0;
  logic [31:0] data_result;
  logic data_exception, data_resultRDY;
  int passed = 0, total = 0;

  multdiv dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .data_operandA (op_a),
    .data_operandB (op_b),
    .ctrl_MULT     (ctrl_mult),
    .ctrl_DIV      (ctrl_div),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic start_op(input logic m, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    op_a = x;
    op_b = y;
    ctrl_mult = m;
    ctrl_div = !m;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    ctrl_div = 1'b0;
    op_a = 32'hDEAD_BEEF;
    op_b = 32'h0;
  endtask

  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    total++; if (data_result !== 32'h0) $display("FAIL reset_result got %h want 00000000", data_result); else passed++;
    total++; if (data_exception !== 1'b0) $display("FAIL reset_exc got %b want 0", data_exception); else passed++;
    total++; if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy got %b want 0", data_resultRDY); else passed++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_mult;
    logic [31:0] va [3] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] vb [3] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] vr [3] = '{32'hFFFF_FFD6, 32'h0, 32'h1};
    logic ve [3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(1'b1, va[i], vb[i]);
      wait_rdy(lat);
      total++; if (lat !== ML) $display("FAIL mult%0d_latency got %0d want %0d", i, lat, ML); else passed++;
      total++; if (data_result !== vr[i]) $display("FAIL mult%0d_result got %h want %h", i, data_result, vr[i]); else passed++;
      total++; if (data_exception !== ve[i]) $display("FAIL mult%0d_exc got %b want %b", i, data_exception, ve[i]); else passed++;
      @(posedge clock);
      #1;
      total++; if (data_resultRDY !== 1'b0) $display("FAIL mult%0d_rdy_pulse got %b want 0", i, data_resultRDY); else passed++;
    end
  endtask

  task automatic test_div;
    logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000};
    logic [31:0] vb [4] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] vr [4] = '{32'hFFFF_FFFD, 32'd14, 32'h0, 32'h8000_0000};
    logic ve [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int vl [4] = '{33, 33, 1, 33};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(1'b0, va[i], vb[i]);
      wait_rdy(lat);
      total++; if (lat !== vl[i]) $display("FAIL div%0d_latency got %0d want %0d", i, lat, vl[i]); else passed++;
      total++; if (data_result !== vr[i]) $display("FAIL div%0d_result got %h want %h", i, data_result, vr[i]); else passed++;
      total++; if (data_exception !== ve[i]) $display("FAIL div%0d_exc got %b want %b", i, data_exception, ve[i]); else passed++;
      @(posedge clock);
      #1;
      total++; if (data_resultRDY !== 1'b0) $display("FAIL div%0d_rdy_pulse got %b want 0", i, data_resultRDY); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(1'b0, 32'd100, 32'd7);
    wait_rdy(lat);
    total++; if (lat !== 33) $display("FAIL b2b_div_latency got %0d want 33", lat); else passed++;
    start_op(1'b1, 32'd7, 32'hFFFF_FFFA);
    total++; if (data_resultRDY !== 1'b0) $display("FAIL b2b_rdy_pulse got %b want 0", data_resultRDY); else passed++;
    total++; if (data_result !== 32'd14) $display("FAIL b2b_hold got %h want 0000000e", data_result); else passed++;
    wait_rdy(lat);
    total++; if (lat !== ML) $display("FAIL b2b_mult_latency got %0d want %0d", lat, ML); else passed++;
    total++; if (data_result !== 32'hFFFF_FFD6) $display("FAIL b2b_mult_result got %h want ffffffd6", data_result); else passed++;
  endtask

  task automatic test_restart;
    int lat, spurious;
    spurious = 0;
    start_op(1'b1, 32'd3, 32'd4);
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) spurious++;
    end
    start_op(1'b0, 32'd100, 32'd7);
    wait_rdy(lat);
    total++; if (spurious !== 0) $display("FAIL restart_spurious got %0d want 0", spurious); else passed++;
    total++; if (lat !== 33) $display("FAIL restart_latency got %0d want 33", lat); else passed++;
    total++; if (data_result !== 32'd14) $display("FAIL restart_result got %h want 0000000e", data_result); else passed++;
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    start_op(1'b0, 32'd100, 32'd7);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    total++; if (data_result !== 32'h0) $display("FAIL midreset_result got %h want 00000000", data_result); else passed++;
    total++; if (data_resultRDY !== 1'b0) $display("FAIL midreset_rdy got %b want 0", data_resultRDY); else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midreset_no_rdy got %0d want 0", seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
